// File: rtl/pci_pkg.sv
// Shared PCI bus definitions: command codes, target state
// encoding and the byte-lane merge used by the target memory.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IGNORE = 3'd1;
  localparam logic [2:0] ST_TAR    = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be_n
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (!be_n[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// Target register array: byte-enabled synchronous write,
// asynchronous read, both on the same pointer.
module pci_target_mem
  import pci_pkg::*;
#(
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= be_merge(mem[addr], wdata, be_n);
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pci_target.sv
// PCI-style memory target: claims a small window, answers
// single and burst reads/writes with zero target wait states.
module pci_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0010,
  parameter int          ADDR_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire [31:0] d,
  input  logic [3:0] C_BE,
  input  logic       frame,
  input  logic       irdy,
  output logic       devsel,
  output logic       trdy
);

  localparam int LSB = ADDR_BITS + 2;

  logic [2:0]           state;
  logic [ADDR_BITS-1:0] ptr;
  logic                 frame_q;
  logic [31:0]          rdata;
  logic                 addr_ph;
  logic                 hit;
  logic                 in_data;
  logic                 we;

  assign addr_ph = !frame && frame_q && (state == ST_IDLE);
  assign hit     = d[31:LSB] == BASE_ADDR[31:LSB];
  assign in_data = (state == ST_WDATA) || (state == ST_RDATA);
  assign we      = (state == ST_WDATA) && !irdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      frame_q <= 1'b1;
    end else begin
      frame_q <= frame;
      case (state)
        ST_IDLE: begin
          if (addr_ph) begin
            ptr <= d[LSB-1:2];
            if (hit && C_BE == CMD_MEM_WRITE)
              state <= ST_WDATA;
            else if (hit && C_BE == CMD_MEM_READ)
              state <= ST_TAR;
            else
              state <= ST_IGNORE;
          end
        end
        ST_IGNORE: begin
          if (frame && irdy) state <= ST_IDLE;
        end
        ST_TAR: state <= ST_RDATA;
        ST_WDATA, ST_RDATA: begin
          // frame high with irdy high ends an aborted burst
          if (!irdy) begin
            ptr <= ptr + 1'b1;
            if (frame) state <= ST_DONE;
          end else if (frame) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign devsel = !(in_data || state == ST_TAR);
  assign trdy   = !in_data;
  assign d      = (state == ST_RDATA) ? rdata : 'z;

  pci_target_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .be_n (C_BE),
    .addr (ptr),
    .wdata(d),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_pci_target.sv
// Bench for pci_target: transaction-level model predicts every
// cycle of devsel/trdy/d; read data also pinned by literals.
module tb_pci_target;

  localparam logic [31:0] BASE = 32'h0000_0010;
  // Initiator parks this on d whenever the target must be silent,
  // so a target driving at the wrong time corrupts the value.
  localparam logic [31:0] PARK = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  C_BE = 4'hf;
  logic        frame = 1'b1;
  logic        irdy = 1'b1;
  logic        devsel;
  logic        trdy;
  logic        drv_en = 1'b1;
  logic [31:0] drv_val = PARK;
  wire  [31:0] d;

  assign d = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  pci_target #(
    .BASE_ADDR(BASE),
    .ADDR_BITS(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .C_BE  (C_BE),
    .frame (frame),
    .irdy  (irdy),
    .devsel(devsel),
    .trdy  (trdy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic        chk_en = 1'b0;
  logic        e_dev, e_trdy, e_oe;
  logic [31:0] e_d;

  logic [31:0] mdl [4];
  logic [31:0] rd_obs [$];

  int          z4 [4] = '{default: 0};
  logic [3:0]  b0 [4] = '{default: 4'h0};
  logic [31:0] w0 [4] = '{default: 32'h0};

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic lit(input string nm, input int k,
                     input logic [31:0] exp);
    logic [31:0] g;
    g = (k < rd_obs.size()) ? rd_obs[k] : 32'hxxxx_xxxx;
    cmp(nm, g, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("devsel", {31'b0, devsel}, {31'b0, e_dev});
      cmp("trdy", {31'b0, trdy}, {31'b0, e_trdy});
      cmp("d", d, e_oe ? e_d : drv_val);
      if (e_oe && !irdy) rd_obs.push_back(d);
    end
  end

  task automatic step(
    input logic fr, input logic ir, input logic [3:0] be,
    input logic [31:0] dv, input logic r,
    input logic xd, input logic xt, input logic xo,
    input logic [31:0] xv
  );
    frame   = fr;
    irdy    = ir;
    C_BE    = be;
    rst     = r;
    drv_en  = !xo;
    drv_val = dv;
    e_dev   = xd;
    e_trdy  = xt;
    e_oe    = xo;
    e_d     = xv;
    chk_en  = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic xact(
    input logic [31:0] addr, input logic [3:0] cmd, input int n,
    input logic [31:0] wd [4], input logic [3:0] be [4],
    input int wt [4], input int rst_at
  );
    bit claim, rd;
    int p;
    claim = (cmd == 4'b0110 || cmd == 4'b0111) &&
            addr >= BASE && addr < BASE + 16;
    rd = claim && cmd == 4'b0110;
    p = (addr - BASE) / 4 % 4;
    rd_obs.delete();
    step(1'b0, 1'b1, cmd, addr, 1'b0, 1, 1, 0, 0);
    if (rd) step(1'b0, 1'b0, 4'h0, PARK, 1'b0, 0, 1, 0, 0);
    if (claim && n == 0)
      step(1'b1, 1'b1, 4'hf, PARK, 1'b0, 0, 0, rd, mdl[p]);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        step(1'b1, 1'b1, 4'hf, PARK, 1'b1, 0, 0, 1, mdl[p]);
        step(1'b1, 1'b1, 4'hf, PARK, 1'b0, 1, 1, 0, 0);
        return;
      end
      for (int w = 0; w < wt[i]; w++)
        step(1'b0, 1'b1, be[i], wd[i], 1'b0,
             !claim, !claim, rd, mdl[p]);
      step(i == n - 1, 1'b0, be[i], wd[i], 1'b0,
           !claim, !claim, rd, mdl[p]);
      if (claim) begin
        if (!rd)
          for (int b = 0; b < 4; b++)
            if (!be[i][b]) mdl[p][8*b +: 8] = wd[i][8*b +: 8];
        p = (p + 1) % 4;
      end
    end
    step(1'b1, 1'b1, 4'hf, PARK, 1'b0, 1, 1, 0, 0);
    step(1'b1, 1'b1, 4'hf, PARK, 1'b0, 1, 1, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // reset state
    step(1'b1, 1'b1, 4'hf, PARK, 1'b0, 1, 1, 0, 0);

    xact(32'h10, 4'b0111, 1, '{32'hDEAD_BEEF, 0, 0, 0}, b0, z4, -1);
    xact(32'h10, 4'b0110, 1, w0, b0, z4, -1);
    lit("single_wr", 0, 32'hDEAD_BEEF);

    xact(32'h10, 4'b0111, 4, '{0, 1, 2, 3}, b0, z4, -1);
    xact(32'h18, 4'b0110, 3, w0, b0, z4, -1);
    lit("burst_rd0", 0, 32'h2);
    lit("burst_rd1", 1, 32'h3);
    lit("burst_wrap", 2, 32'h0);

    xact(32'h14, 4'b0111, 1, '{32'hFFFF_FFFF, 0, 0, 0}, b0, z4, -1);
    xact(32'h14, 4'b0111, 1, '{32'h1234_5678, 0, 0, 0},
         '{4'b1010, 4'h0, 4'h0, 4'h0}, z4, -1);
    xact(32'h17, 4'b0110, 1, w0, b0, z4, -1);
    lit("byte_en", 0, 32'hFF34_FF78);

    xact(32'h40, 4'b0111, 2, '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 0, 0},
         b0, z4, -1);
    xact(32'h10, 4'b0010, 1, '{32'hCCCC_CCCC, 0, 0, 0}, b0, z4, -1);
    xact(32'h10, 4'b0110, 4, w0, b0, z4, -1);
    lit("miss_m0", 0, 32'h0);
    lit("miss_m1", 1, 32'hFF34_FF78);

    xact(32'h10, 4'b0110, 4, w0, b0, '{0, 2, 0, 0}, -1);
    lit("wait_w1", 1, 32'hFF34_FF78);
    lit("wait_w2", 2, 32'h2);
    lit("wait_w3", 3, 32'h3);

    xact(32'h1C, 4'b0111, 2, '{32'h1111_2222, 32'h3333_4444, 0, 0},
         b0, '{1, 0, 0, 0}, -1);

    xact(32'h10, 4'b0110, 4, w0, b0, z4, 2);
    xact(32'h10, 4'b0110, 4, w0, b0, z4, -1);
    lit("rst_m0", 0, 32'h3333_4444);
    lit("rst_m3", 3, 32'h1111_2222);

    xact(32'h14, 4'b0111, 0, w0, b0, z4, -1);
    xact(32'h14, 4'b0110, 1, w0, b0, z4, -1);
    lit("abort_keep", 0, 32'hFF34_FF78);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
